// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the synchronous IMEM address and
// the IF/ID latch, handles redirects (branch/return/interrupt) by squashing the
// wrong-path fetch that is already in flight.
module fetch_stage #(
  parameter int unsigned       PC_W       = 10,
  parameter int unsigned       INSTR_W    = 18,
  parameter logic [PC_W-1:0]   RESET_PC   = '0,
  parameter logic [PC_W-1:0]   INT_VECTOR = '1,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pc_inc,
  input  logic               pc_load,
  input  logic [PC_W-1:0]    pc_load_addr,
  input  logic               int_req,
  input  logic               fetch_latch_stall,
  input  logic               imem_addr_mux,
  input  logic               dec_nop,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  output logic               if_valid,
  output logic [PC_W-1:0]    int_ret_pc,
  output logic [1:0]         fe_state
);

  localparam logic [1:0] ST_FILL   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;
  localparam logic [1:0] ST_SQUASH = 2'd3;

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] fetch_pc_q;
  logic [1:0]      state_q;
  logic [1:0]      state_d;
  logic            redirect;
  logic            bubble;

  assign redirect = int_req | pc_load;
  // Data arriving now belongs to a pre-first-fetch or squashed address.
  assign bubble   = dec_nop | (state_q == ST_FILL) | (state_q == ST_SQUASH);

  // IMEM address: replay the last issued address while the decoder re-reads it.
  assign imem_addr = imem_addr_mux ? fetch_pc_q : pc_q;
  assign fe_state  = state_q;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a stall keeps a pending fill/squash alive until it releases.
  always_comb begin
    state_d = ST_RUN;
    if (redirect) begin
      state_d = ST_SQUASH;
    end else if (fetch_latch_stall) begin
      if ((state_q == ST_FILL) || (state_q == ST_SQUASH)) begin
        state_d = state_q;
      end else begin
        state_d = ST_HOLD;
      end
    end
  end

  // PC update: interrupt beats load beats stall beats increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (int_req) begin
      pc_q <= INT_VECTOR;
    end else if (pc_load) begin
      pc_q <= pc_load_addr;
    end else if (fetch_latch_stall) begin
      pc_q <= pc_q;
    end else if (pc_inc) begin
      pc_q <= pc_q + PC_W'(1);
    end
  end

  // Remember the address whose data appears on imem_data next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
    end else if (!fetch_latch_stall) begin
      fetch_pc_q <= imem_addr;
    end
  end

  // Interrupt return address: a same-cycle branch target takes precedence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      int_ret_pc <= '0;
    end else if (int_req) begin
      int_ret_pc <= pc_load ? pc_load_addr : fetch_pc_q;
    end
  end

  // IF/ID latch: frozen on stall, bubble on fill/squash/decoder request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_instr <= NOP_INSTR;
      if_pc    <= '0;
      if_valid <= 1'b0;
    end else if (!fetch_latch_stall) begin
      if_pc <= fetch_pc_q;
      if (bubble) begin
        if_instr <= NOP_INSTR;
        if_valid <= 1'b0;
      end else begin
        if_instr <= imem_data;
        if_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random traffic, all checked
// against a slot-level reference model of the fetch pipeline.
module tb_fetch_stage;

  localparam int unsigned PC_W    = 10;
  localparam int unsigned INSTR_W = 18;

  logic               clk;
  logic               reset;
  logic               pc_inc;
  logic               pc_load;
  logic [PC_W-1:0]    pc_load_addr;
  logic               int_req;
  logic               fetch_latch_stall;
  logic               imem_addr_mux;
  logic               dec_nop;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] if_instr;
  logic [PC_W-1:0]    if_pc;
  logic               if_valid;
  logic [PC_W-1:0]    int_ret_pc;
  logic [1:0]         fe_state;

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk               (clk),
    .reset             (reset),
    .pc_inc            (pc_inc),
    .pc_load           (pc_load),
    .pc_load_addr      (pc_load_addr),
    .int_req           (int_req),
    .fetch_latch_stall (fetch_latch_stall),
    .imem_addr_mux     (imem_addr_mux),
    .dec_nop           (dec_nop),
    .imem_addr         (imem_addr),
    .imem_data         (imem_data),
    .if_instr          (if_instr),
    .if_pc             (if_pc),
    .if_valid          (if_valid),
    .int_ret_pc        (int_ret_pc),
    .fe_state          (fe_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [INSTR_W-1:0] mem_word(input logic [PC_W-1:0] a);
    return INSTR_W'(a) + INSTR_W'(18'h100);
  endfunction

  // Synchronous instruction memory: word = address + 0x100.
  always @(posedge clk) imem_data <= mem_word(imem_addr);

  // Reference model: next PC, address in flight, what the in-flight data is worth,
  // and the IF/ID contents.
  logic [PC_W-1:0]    m_pc, m_fetch, m_last_addr, m_ifpc, m_ret;
  logic [INSTR_W-1:0] m_instr;
  logic               m_valid, m_fill, m_squash, m_hold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = '0; m_fetch = '0; m_last_addr = '0; m_ifpc = '0; m_ret = '0;
    m_instr = '0; m_valid = 1'b0; m_fill = 1'b1; m_squash = 1'b0; m_hold = 1'b0;
  endtask

  function automatic logic [1:0] m_state();
    if (m_squash) return 2'd3;
    if (m_fill)   return 2'd0;
    if (m_hold)   return 2'd2;
    return 2'd1;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".if_instr"}, 32'(if_instr), 32'(m_instr));
    chk({tag, ".if_pc"}, 32'(if_pc), 32'(m_ifpc));
    chk({tag, ".if_valid"}, 32'(if_valid), 32'(m_valid));
    chk({tag, ".int_ret_pc"}, 32'(int_ret_pc), 32'(m_ret));
    chk({tag, ".fe_state"}, 32'(fe_state), 32'(m_state()));
  endtask

  // One clock cycle: drive, check address, advance model across the edge, check latch.
  task automatic step(input logic inc, input logic ld, input logic [PC_W-1:0] la,
                      input logic irq, input logic st, input logic mx, input logic dn);
    logic [PC_W-1:0] a;
    logic            waiting;
    pc_inc = inc; pc_load = ld; pc_load_addr = la; int_req = irq;
    fetch_latch_stall = st; imem_addr_mux = mx; dec_nop = dn;
    #1;
    a = mx ? m_fetch : m_pc;
    chk("imem_addr", 32'(imem_addr), 32'(a));
    @(posedge clk);
    #1;
    waiting = m_fill | m_squash;
    if (!st) begin
      m_ifpc = m_fetch;
      if (dn || waiting) begin
        m_instr = '0; m_valid = 1'b0;
      end else begin
        m_instr = mem_word(m_last_addr); m_valid = 1'b1;
      end
      m_fetch = a;
    end
    if (irq) m_ret = ld ? la : m_fetch_prev(st, a);
    if (irq)            m_pc = 10'h3FF;
    else if (ld)        m_pc = la;
    else if (!st && inc) m_pc = m_pc + 10'd1;
    if (irq || ld) begin
      m_squash = 1'b1; m_fill = 1'b0; m_hold = 1'b0;
    end else if (st) begin
      if (!waiting) m_hold = 1'b1;
    end else begin
      m_squash = 1'b0; m_fill = 1'b0; m_hold = 1'b0;
    end
    m_last_addr = a;
    check_outputs("cycle");
  endtask

  // Address in flight before this edge (m_fetch was already advanced above).
  logic [PC_W-1:0] fetch_before;
  function automatic logic [PC_W-1:0] m_fetch_prev(input logic st, input logic [PC_W-1:0] a);
    return fetch_before;
  endfunction

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      fetch_before = m_fetch;
      step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic go(input logic inc, input logic ld, input logic [PC_W-1:0] la,
                    input logic irq, input logic st, input logic mx, input logic dn);
    fetch_before = m_fetch;
    step(inc, ld, la, irq, st, mx, dn);
  endtask

  initial begin
    int n;
    reset = 1'b1; pc_inc = 1'b0; pc_load = 1'b0; pc_load_addr = '0; int_req = 1'b0;
    fetch_latch_stall = 1'b0; imem_addr_mux = 1'b0; dec_nop = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    chk("reset.imem_addr", 32'(imem_addr), 32'h0);
    reset = 1'b0;

    // 1: sequential fetch after reset release.
    go(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1.first_bubble", 32'(if_valid), 32'h0);
    for (int k = 2; k <= 7; k++) begin
      go(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t1.if_pc", 32'(if_pc), 32'(k - 2));
      chk("t1.if_instr", 32'(if_instr), 32'(32'h100 + k - 2));
      chk("t1.if_valid", 32'(if_valid), 32'h1);
    end

    // 2: three-cycle stall with address replay.
    for (int k = 0; k < 3; k++) begin
      go(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("t2.imem_addr", 32'(imem_addr), 32'h6);
      chk("t2.if_pc", 32'(if_pc), 32'h5);
      chk("t2.fe_state", 32'(fe_state), 32'h2);
    end
    go(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2.rel_pc", 32'(if_pc), 32'h6);
    chk("t2.rel_instr", 32'(if_instr), 32'h106);
    go(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2.rel_pc2", 32'(if_pc), 32'h7);

    // 3: branch to 0x40 while address 9 is in flight.
    go(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3.fetch9", 32'(m_fetch), 32'h9);
    go(1'b1, 1'b1, 10'h40, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3.squash", 32'(fe_state), 32'h3);
    go(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3.bubble", 32'(if_valid), 32'h0);
    go(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3.target", 32'(if_pc), 32'h40);
    chk("t3.target_valid", 32'(if_valid), 32'h1);
    go(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3.target_next", 32'(if_pc), 32'h41);

    // 4: interrupt with 0x12 in flight, vector wraps to 0.
    go(1'b1, 1'b1, 10'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (m_fetch != 10'h12 && n < 20) begin
      go(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("t4.reach_0x12", 32'(m_fetch), 32'h12);
    go(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t4.int_ret_pc", 32'(int_ret_pc), 32'h12);
    go(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4.bubble", 32'(if_valid), 32'h0);
    go(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4.vector", 32'(if_pc), 32'h3FF);
    chk("t4.vector_instr", 32'(if_instr), 32'h4FF);
    go(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4.wrap", 32'(if_pc), 32'h0);

    // 5: interrupt and branch together.
    go(1'b1, 1'b1, 10'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t5.int_ret_pc", 32'(int_ret_pc), 32'h55);
    run(2);
    chk("t5.vector", 32'(if_pc), 32'h3FF);

    // 6: asynchronous reset in the middle of a stall.
    go(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    go(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs("t6.async");
    chk("t6.fe_state", 32'(fe_state), 32'h0);
    chk("t6.imem_addr", 32'(imem_addr), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    pc_inc = 1'b0; fetch_latch_stall = 1'b0; imem_addr_mux = 1'b0;

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic inc, ld, irq, st, mx, dn;
      logic [PC_W-1:0] la;
      inc = ($urandom % 8) != 0;
      ld  = ($urandom % 14) == 0;
      irq = ($urandom % 30) == 0;
      st  = ($urandom % 6) == 0;
      mx  = st ? 1'($urandom % 2) : (($urandom % 8) == 0);
      dn  = ($urandom % 10) == 0;
      la  = PC_W'($urandom);
      go(inc, ld, la, irq, st, mx, dn);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
